// File: rtl/cm_event_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cm_event_arbiter_pkg
// Shared definitions for the CM event arbiter:
//   - code/data widths of the three CM event sources
//   - evt_src_e : outbound source tag (NONE/ERR/CFG/VGA)
//   - out_state_e : output register FSM states
//   - bit positions inside the 6-bit status word
//   - maxOf3 : width helper used to size the merged code bus
// ---------------------------------------------------------------------------
package cm_event_arbiter_pkg;

    localparam int CONFIG_NOTIFICATION_WIDTH = 8;
    localparam int CONFIG_ERROR_WIDTH        = 8;
    localparam int VGA_NOTIFICATION_WIDTH    = 8;
    localparam int DATA_WIDTH                = 32;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ERR  = 2'd1,
        CFG  = 2'd2,
        VGA  = 2'd3
    } evt_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } out_state_e;

    localparam int STATUS_W      = 6;
    localparam int STAT_PEND_ERR = 0;
    localparam int STAT_PEND_CFG = 1;
    localparam int STAT_PEND_VGA = 2;
    localparam int STAT_OVF_ERR  = 3;
    localparam int STAT_OVF_CFG  = 4;
    localparam int STAT_OVF_VGA  = 5;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cm_event_slot.sv
// ---------------------------------------------------------------------------
// cm_event_slot
// One-deep holding register for a single event source.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_strobe       : source strobe, i_code/i_data captured with it
//   i_free         : slot contents move to the output register this edge
//   i_ovfClr       : clears the sticky overflow flag
//   o_pending      : slot holds an event
//   o_code/o_data  : held event
//   o_promoted     : aging enabled and the event has waited AGE_MAX edges
//   o_ovf          : sticky, a strobe was dropped because the slot was full
// ---------------------------------------------------------------------------
module cm_event_slot
    import cm_event_arbiter_pkg::*;
#(
    parameter int CODE_W  = 8,
    parameter int DATA_W  = 32,
    parameter bit AGING   = 1'b1,
    parameter int AGE_MAX = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_strobe,
    input  logic [CODE_W-1:0] i_code,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_free,
    input  logic              i_ovfClr,
    output logic              o_pending,
    output logic [CODE_W-1:0] o_code,
    output logic [DATA_W-1:0] o_data,
    output logic              o_promoted,
    output logic              o_ovf
);

    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic              r_pending;
    logic [CODE_W-1:0] r_code;
    logic [DATA_W-1:0] r_data;
    logic [AGE_W-1:0]  r_age;
    logic              r_ovf;
    logic              w_capture;
    logic              w_overflow;

    // A slot that is handing its event to the output on this edge counts
    // as free, so a strobe arriving on that same edge is still accepted.
    assign w_capture  = i_strobe && (!r_pending || i_free);
    assign w_overflow = i_strobe && r_pending && !i_free;

    // Pending flag and payload. A capture wins over the free so the slot
    // stays occupied when it empties and refills on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= 1'b0;
            r_code    <= '0;
            r_data    <= '0;
        end else if (w_capture) begin
            r_pending <= 1'b1;
            r_code    <= i_code;
            r_data    <= i_data;
        end else if (i_free) begin
            r_pending <= 1'b0;
        end
    end

    // Sticky overflow. A fresh overflow beats a simultaneous clear so no
    // dropped event can go unreported.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_overflow) begin
            r_ovf <= 1'b1;
        end else if (i_ovfClr) begin
            r_ovf <= 1'b0;
        end
    end

    // Age counts edges the event sat pending without being picked. It
    // restarts on transfer (a refill on that edge is a brand-new event)
    // and saturates so promotion stays asserted until the event leaves.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_age <= '0;
        end else if (!AGING || !r_pending || i_free) begin
            r_age <= '0;
        end else if (r_age != AGE_W'(AGE_MAX)) begin
            r_age <= r_age + AGE_W'(1);
        end
    end

    assign o_pending  = r_pending;
    assign o_code     = r_code;
    assign o_data     = r_data;
    assign o_ovf      = r_ovf;
    assign o_promoted = AGING && r_pending && (r_age == AGE_W'(AGE_MAX));

endmodule

// File: rtl/cm_event_arbiter.sv
// ---------------------------------------------------------------------------
// cm_event_arbiter
// Merges CM config notifications, config errors and VGA notifications onto
// one valid/ready event channel.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_cfg_notif(_valid)   : config notification code + strobe
//   i_err_code, i_err_valid : config error code + strobe
//   i_vga_notif(_valid), i_vga_data : VGA notification code/data + strobe
//   o_evt_valid, i_evt_ready : outbound handshake
//   o_evt_src             : 1=err 2=cfg 3=vga, 0 when idle
//   o_evt_code/o_evt_data : event payload (code zero-extended)
//   o_status              : {ovf_vga, ovf_cfg, ovf_err, pend_vga, pend_cfg, pend_err}
//   i_status_clr          : clears the sticky overflow bits
//   o_evt_count           : accepted events, wrapping
// ---------------------------------------------------------------------------
module cm_event_arbiter
    import cm_event_arbiter_pkg::*;
#(
    parameter int CFG_NOTIF_W = CONFIG_NOTIFICATION_WIDTH,
    parameter int ERR_W       = CONFIG_ERROR_WIDTH,
    parameter int VGA_NOTIF_W = VGA_NOTIFICATION_WIDTH,
    parameter int DATA_W      = DATA_WIDTH,
    parameter int AGE_MAX     = 15,
    parameter int CNT_W       = 16,
    localparam int CODE_W     = maxOf3(CFG_NOTIF_W, ERR_W, VGA_NOTIF_W)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [CFG_NOTIF_W-1:0] i_cfg_notif,
    input  logic                   i_cfg_notif_valid,
    input  logic [ERR_W-1:0]       i_err_code,
    input  logic                   i_err_valid,
    input  logic [VGA_NOTIF_W-1:0] i_vga_notif,
    input  logic                   i_vga_notif_valid,
    input  logic [DATA_W-1:0]      i_vga_data,
    output logic                   o_evt_valid,
    input  logic                   i_evt_ready,
    output logic [1:0]             o_evt_src,
    output logic [CODE_W-1:0]      o_evt_code,
    output logic [DATA_W-1:0]      o_evt_data,
    output logic [STATUS_W-1:0]    o_status,
    input  logic                   i_status_clr,
    output logic [CNT_W-1:0]       o_evt_count
);

    out_state_e        r_state;
    out_state_e        w_nextState;
    evt_src_e          r_evtSrc;
    logic [CODE_W-1:0] r_evtCode;
    logic [DATA_W-1:0] r_evtData;
    logic [CNT_W-1:0]  r_count;

    logic              w_pendErr, w_pendCfg, w_pendVga;
    logic              w_promCfg, w_promVga, w_promErr;
    logic              w_ovfErr, w_ovfCfg, w_ovfVga;
    logic [CODE_W-1:0] w_errCode, w_cfgCode, w_vgaCode;
    logic [DATA_W-1:0] w_errData, w_cfgData, w_vgaData;
    logic              w_anyPend, w_accept, w_load;
    evt_src_e          w_winner;
    logic [CODE_W-1:0] w_nextCode;
    logic [DATA_W-1:0] w_nextData;

    cm_event_slot #(
        .CODE_W(CODE_W), .DATA_W(DATA_W), .AGING(1'b0), .AGE_MAX(AGE_MAX)
    ) u_errSlot (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_strobe(i_err_valid), .i_code(CODE_W'(i_err_code)), .i_data('0),
        .i_free(w_load && (w_winner == ERR)), .i_ovfClr(i_status_clr),
        .o_pending(w_pendErr), .o_code(w_errCode), .o_data(w_errData),
        .o_promoted(w_promErr), .o_ovf(w_ovfErr)
    );

    cm_event_slot #(
        .CODE_W(CODE_W), .DATA_W(DATA_W), .AGING(1'b1), .AGE_MAX(AGE_MAX)
    ) u_cfgSlot (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_strobe(i_cfg_notif_valid), .i_code(CODE_W'(i_cfg_notif)), .i_data('0),
        .i_free(w_load && (w_winner == CFG)), .i_ovfClr(i_status_clr),
        .o_pending(w_pendCfg), .o_code(w_cfgCode), .o_data(w_cfgData),
        .o_promoted(w_promCfg), .o_ovf(w_ovfCfg)
    );

    cm_event_slot #(
        .CODE_W(CODE_W), .DATA_W(DATA_W), .AGING(1'b1), .AGE_MAX(AGE_MAX)
    ) u_vgaSlot (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_strobe(i_vga_notif_valid), .i_code(CODE_W'(i_vga_notif)), .i_data(i_vga_data),
        .i_free(w_load && (w_winner == VGA)), .i_ovfClr(i_status_clr),
        .o_pending(w_pendVga), .o_code(w_vgaCode), .o_data(w_vgaData),
        .o_promoted(w_promVga), .o_ovf(w_ovfVga)
    );

    // The output register takes a new event whenever it is empty or its
    // current event is being accepted, which gives back-to-back transfers.
    assign w_anyPend = w_pendErr || w_pendCfg || w_pendVga;
    assign w_accept  = (r_state == ST_HOLD) && i_evt_ready;
    assign w_load    = w_anyPend && ((r_state == ST_IDLE) || w_accept);

    // Fixed priority err > cfg > vga, but an aged-out cfg or vga jumps
    // ahead of err. The err slot never ages, so w_promErr is always low
    // and only kept to give the slot output a home.
    always_comb begin
        w_winner = NONE;
        if (w_promCfg) begin
            w_winner = CFG;
        end else if (w_promVga) begin
            w_winner = VGA;
        end else if (w_pendErr || w_promErr) begin
            w_winner = ERR;
        end else if (w_pendCfg) begin
            w_winner = CFG;
        end else if (w_pendVga) begin
            w_winner = VGA;
        end
    end

    // Payload of the winning slot. Err and cfg slots are fed zero data so
    // the data field reads 0 for them without extra masking.
    always_comb begin
        w_nextCode = '0;
        w_nextData = '0;
        case (w_winner)
            ERR: begin
                w_nextCode = w_errCode;
                w_nextData = w_errData;
            end
            CFG: begin
                w_nextCode = w_cfgCode;
                w_nextData = w_cfgData;
            end
            VGA: begin
                w_nextCode = w_vgaCode;
                w_nextData = w_vgaData;
            end
            default: begin
            end
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Output FSM next state: stay in HOLD while there is either an
    // unaccepted event or a follow-on event ready to load.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_anyPend) w_nextState = ST_HOLD;
            ST_HOLD: if (w_accept)  w_nextState = w_anyPend ? ST_HOLD : ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Output register payload, only updated when a new winner is loaded so
    // it stays stable under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_evtSrc  <= NONE;
            r_evtCode <= '0;
            r_evtData <= '0;
        end else if (w_load) begin
            r_evtSrc  <= w_winner;
            r_evtCode <= w_nextCode;
            r_evtData <= w_nextData;
        end
    end

    // Accepted-event counter, wraps naturally at its width.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Output FSM outputs: the channel reads all-zero while idle, so a stale
    // payload left in the register after the last accept is never visible.
    always_comb begin
        o_evt_valid = 1'b0;
        o_evt_src   = NONE;
        o_evt_code  = '0;
        o_evt_data  = '0;
        if (r_state == ST_HOLD) begin
            o_evt_valid = 1'b1;
            o_evt_src   = r_evtSrc;
            o_evt_code  = r_evtCode;
            o_evt_data  = r_evtData;
        end
    end

    assign o_status[STAT_PEND_ERR] = w_pendErr;
    assign o_status[STAT_PEND_CFG] = w_pendCfg;
    assign o_status[STAT_PEND_VGA] = w_pendVga;
    assign o_status[STAT_OVF_ERR]  = w_ovfErr;
    assign o_status[STAT_OVF_CFG]  = w_ovfCfg;
    assign o_status[STAT_OVF_VGA]  = w_ovfVga;
    assign o_evt_count             = r_count;

endmodule

// File: tb/tb_cm_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cm_event_arbiter
// Directed scenarios followed by random traffic on cm_event_arbiter. A
// transaction-level model (per-source arrays indexed by source number)
// predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_cm_event_arbiter;

    localparam int CNT_W   = 4;
    localparam int AGE_MAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfgNotif, errCode, vgaNotif;
    logic        cfgNotifValid, errValid, vgaNotifValid;
    logic [31:0] vgaData;
    logic        evtValid, evtReady, statusClr;
    logic [1:0]  evtSrc;
    logic [7:0]  evtCode;
    logic [31:0] evtData;
    logic [5:0]  status;
    logic [CNT_W-1:0] evtCount;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state; index 1=err, 2=cfg, 3=vga (same as src tag).
    bit          mPend[1:3];
    logic [7:0]  mCode[1:3];
    logic [31:0] mVgaData;
    int          mAge[1:3];
    bit          mOvf[1:3];
    bit          mHold;
    int          mSrc;
    logic [7:0]  mOutCode;
    logic [31:0] mOutData;
    int          mCount;

    always #5 clk = ~clk;

    cm_event_arbiter #(.AGE_MAX(AGE_MAX), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cfg_notif(cfgNotif), .i_cfg_notif_valid(cfgNotifValid),
        .i_err_code(errCode), .i_err_valid(errValid),
        .i_vga_notif(vgaNotif), .i_vga_notif_valid(vgaNotifValid),
        .i_vga_data(vgaData),
        .o_evt_valid(evtValid), .i_evt_ready(evtReady),
        .o_evt_src(evtSrc), .o_evt_code(evtCode), .o_evt_data(evtData),
        .o_status(status), .i_status_clr(statusClr),
        .o_evt_count(evtCount)
    );

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        for (int s = 1; s <= 3; s++) begin
            mPend[s] = 1'b0;
            mCode[s] = '0;
            mAge[s]  = 0;
            mOvf[s]  = 1'b0;
        end
        mVgaData = '0;
        mHold    = 1'b0;
        mSrc     = 0;
        mOutCode = '0;
        mOutData = '0;
        mCount   = 0;
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    function automatic void modelStep();
        bit         strobe[1:3];
        logic [7:0] inCode[1:3];
        bit         accept;
        int         winner;
        strobe[1] = errValid;      inCode[1] = errCode;
        strobe[2] = cfgNotifValid; inCode[2] = cfgNotif;
        strobe[3] = vgaNotifValid; inCode[3] = vgaNotif;
        accept = mHold && evtReady;
        winner = 0;
        if (!mHold || accept) begin
            for (int s = 2; s <= 3; s++)
                if (winner == 0 && mPend[s] && mAge[s] == AGE_MAX) winner = s;
            for (int s = 1; s <= 3; s++)
                if (winner == 0 && mPend[s]) winner = s;
        end
        if (accept) begin
            mCount = (mCount + 1) % (1 << CNT_W);
            mHold  = 1'b0;
        end
        if (winner != 0) begin
            mHold    = 1'b1;
            mSrc     = winner;
            mOutCode = mCode[winner];
            mOutData = (winner == 3) ? mVgaData : 32'd0;
        end
        for (int s = 1; s <= 3; s++) begin
            if (winner == s) begin
                mPend[s] = 1'b0;
                mAge[s]  = 0;
            end else if (mPend[s] && s != 1) begin
                mAge[s] = (mAge[s] < AGE_MAX) ? mAge[s] + 1 : AGE_MAX;
            end
            if (strobe[s] && mPend[s]) mOvf[s] = 1'b1;
            else if (statusClr)        mOvf[s] = 1'b0;
            if (strobe[s] && !mPend[s]) begin
                mPend[s] = 1'b1;
                mCode[s] = inCode[s];
                mAge[s]  = 0;
                if (s == 3) mVgaData = vgaData;
            end
        end
    endfunction

    task automatic checkAll();
        checkOutput("evtValid", evtValid, mHold);
        checkOutput("evtSrc",   evtSrc,   mHold ? mSrc : 0);
        checkOutput("evtCode",  evtCode,  mHold ? mOutCode : 8'd0);
        checkOutput("evtData",  evtData,  mHold ? mOutData : 32'd0);
        checkOutput("status",   status,   {mOvf[3], mOvf[2], mOvf[1], mPend[3], mPend[2], mPend[1]});
        checkOutput("evtCount", evtCount, mCount);
    endtask

    // Drives one cycle of inputs, steps the model, then checks after the edge.
    task automatic applyStimulus(input bit sErr, input bit sCfg, input bit sVga,
                                 input bit ready, input bit clr,
                                 input logic [7:0] cErr, input logic [7:0] cCfg,
                                 input logic [7:0] cVga, input logic [31:0] dVga);
        errValid = sErr;      errCode  = cErr;
        cfgNotifValid = sCfg; cfgNotif = cCfg;
        vgaNotifValid = sVga; vgaNotif = cVga; vgaData = dVga;
        evtReady = ready;     statusClr = clr;
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idleCycle(input bit ready, input bit clr);
        applyStimulus(1'b0, 1'b0, 1'b0, ready, clr, 8'd0, 8'd0, 8'd0, 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        errValid = 1'b0; cfgNotifValid = 1'b0; vgaNotifValid = 1'b0;
        statusClr = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        checkAll();
        rst = 1'b0;
    endtask

    initial begin
        int grantCycle;
        rst = 1'b1;
        cfgNotif = '0; errCode = '0; vgaNotif = '0; vgaData = '0;
        cfgNotifValid = 1'b0; errValid = 1'b0; vgaNotifValid = 1'b0;
        evtReady = 1'b0; statusClr = 1'b0;
        @(negedge clk);
        doReset();
        checkOutput("resetValid", evtValid, 0);
        checkOutput("resetStatus", status, 0);

        // Single error event: strobe, pending, then valid two edges later.
        applyStimulus(1, 0, 0, 1, 0, 8'h5A, 8'h00, 8'h00, 32'h0);
        checkOutput("singlePendErr", status[0], 1);
        idleCycle(1, 0);
        checkOutput("singleSrc", evtSrc, 1);
        checkOutput("singleCode", evtCode, 8'h5A);
        checkOutput("singleData", evtData, 0);
        idleCycle(1, 0);
        checkOutput("singleCount", evtCount, 1);

        // Simultaneous strobes drain as err, cfg, vga with no bubble.
        applyStimulus(1, 1, 1, 1, 0, 8'h22, 8'h11, 8'h33, 32'hDEADBEEF);
        idleCycle(1, 0);
        checkOutput("prioFirst", evtSrc, 1);
        idleCycle(1, 0);
        checkOutput("prioSecond", evtSrc, 2);
        checkOutput("prioSecondCode", evtCode, 8'h11);
        idleCycle(1, 0);
        checkOutput("prioThird", evtSrc, 3);
        checkOutput("prioThirdData", evtData, 32'hDEADBEEF);
        idleCycle(1, 0);
        checkOutput("prioIdle", evtValid, 0);
        checkOutput("prioCount", evtCount, 4);

        // Backpressure on a cfg event.
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h44, 8'h00, 32'h0);
        for (int i = 0; i < 11; i++) idleCycle(0, 0);
        checkOutput("bpSrc", evtSrc, 2);
        checkOutput("bpCode", evtCode, 8'h44);
        idleCycle(1, 0);
        checkOutput("bpCount", evtCount, 5);
        idleCycle(1, 0);

        // VGA overflow, clear, and clear colliding with a new overflow.
        for (int i = 1; i <= 3; i++)
            applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'(i), 32'(i * 32'h01010101));
        checkOutput("ovfSet", status[5], 1);
        idleCycle(0, 1);
        checkOutput("ovfCleared", status[5], 0);
        applyStimulus(0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h77, 32'h77);
        checkOutput("ovfClrCollide", status[5], 1);
        for (int i = 0; i < 5; i++) idleCycle(1, 1);

        // Aging: vga passed over by a continuous err stream until promoted.
        doReset();
        applyStimulus(1, 0, 1, 1, 0, 8'hE0, 8'h00, 8'h99, 32'hCAFE0001);
        grantCycle = 0;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 8'(i), 8'h00, 8'h00, 32'h0);
            if (grantCycle == 0 && evtValid && evtSrc == 2'd3) grantCycle = i;
        end
        checkOutput("agingGrantCycle", grantCycle, 16);
        for (int i = 0; i < 4; i++) idleCycle(1, 1);

        // Counter wrap with a 4-bit counter: 17 accepts leave it at 1.
        doReset();
        for (int i = 0; i < 17; i++) applyStimulus(1, 0, 0, 1, 0, 8'(i), 8'h00, 8'h00, 32'h0);
        for (int i = 0; i < 4; i++) idleCycle(1, 0);
        checkOutput("wrapCount", evtCount, 1);

        // Random traffic, including occasional reset mid-handshake.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199, 0) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0,
                              $urandom_range(2, 0) == 0, $urandom_range(9, 0) < 7,
                              $urandom_range(15, 0) == 0,
                              8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                              8'($urandom_range(255, 0)), $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/cm_event_arbiter.md
Name: cm_event_arbiter

Overview:
- Merges the three CM event sources onto one outbound event channel with a valid/ready handshake:
  - configuration notifications;
  - configuration errors;
  - VGA notifications, which carry pixel data.
- Holds one pending event per source and arbitrates by fixed priority with anti-starvation aging.
- Reports pending and overflow state plus an accepted-event counter.
- Sits between the CM core outputs and the downstream notification consumer.

Parameters:
- CFG_NOTIF_W, 8, configuration notification code width (shared package value).
- ERR_W, 8, configuration error code width (shared package value).
- VGA_NOTIF_W, 8, VGA notification code width (shared package value).
- DATA_W, 32, VGA data width (shared package value).
- AGE_MAX, 15, cycles a pending low-priority event may be passed over before it is promoted.
- CNT_W, 16, accepted-event counter width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_notif  in  CFG_NOTIF_W  config notification code.
- cfg_notif_valid  in  1  config notification strobe.
- err_code  in  ERR_W  config error code.
- err_valid  in  1  error strobe.
- vga_notif  in  VGA_NOTIF_W  VGA notification code.
- vga_notif_valid  in  1  VGA notification strobe.
- vga_data  in  DATA_W  data captured with vga_notif.
- evt_valid  out  1  outbound event valid.
- evt_ready  in  1  consumer accepts when evt_valid&evt_ready.
- evt_src  out  2  source: 1=err, 2=cfg, 3=vga, 0 when idle.
- evt_code  out  CODE_W  code, zero-extended; CODE_W = max of the three code widths.
- evt_data  out  DATA_W  vga_data for src 3, else 0.
- status  out  6  {ovf_vga, ovf_cfg, ovf_err, pend_vga, pend_cfg, pend_err}.
- status_clr  in  1  clears the sticky ovf bits.
- evt_count  out  CNT_W  accepted events, wraps at 2^CNT_W.

Behaviour:
- Reset (rst=1 at a posedge):
  - all slots empty, age counters 0;
  - outputs 0: evt_valid, evt_src, evt_code, evt_data, status, evt_count;
  - output FSM goes to IDLE;
  - reset mid-handshake discards the held event without counting it.
- Slots: one per source, each holding code (+data for vga) and a pending flag.
- Slot capture: at a posedge with strobe=1, the slot loads if it is empty or is being transferred to the output register on that same edge.
- Overflow: strobe=1 while the slot is full and not freeing → input dropped, ovf_<src> set (sticky).
- status_clr: clears the ovf bits on the next edge; a new overflow on the same edge wins (bit stays 1).
- Output FSM:
  - IDLE: evt_valid=0. On the edge where any slot is pending, load the arbitration winner into the output register and go to HOLD.
  - HOLD: evt_valid=1; evt_src, evt_code and evt_data are stable until accepted.
  - On evt_valid&evt_ready: evt_count increments. If another slot is pending (including one captured on this edge's view of the pending flags), load the next winner and stay in HOLD (back-to-back, no bubble); otherwise go to IDLE.
- Arbitration:
  - Candidates are pending slots only; a slot being loaded on the same edge is not yet a candidate.
  - Priority err > cfg > vga, except a slot whose age == AGE_MAX is promoted above err; if both cfg and vga are promoted, cfg wins.
- Age counters (cfg, vga only):
  - increment each edge the slot is pending but not transferred, saturating at AGE_MAX;
  - reset to 0 on transfer or when the slot is empty.
- Latency:
  - strobe at edge N → slot pending after N → evt_valid high after edge N+1 if the output is free;
  - minimum two cycles from strobe to evt_valid.
- Simultaneous strobes on all three sources are all captured (separate slots).
- status pend bits reflect slot pending flags after each edge.
- Arithmetic:
  - evt_count wraps modulo 2^CNT_W;
  - evt_code upper bits are 0 for narrower sources.

Decomposition:
- Shared package holds:
  - CONFIG_NOTIFICATION_WIDTH, CONFIG_ERROR_WIDTH, VGA_NOTIFICATION_WIDTH, DATA_WIDTH;
  - an evt_src_e enum (NONE=0, ERR=1, CFG=2, VGA=3);
  - the status bit-index constants.
- One natural sub-module, cm_event_slot: a single pending register with capture/overflow/free logic and an optional aging counter, instantiated three times (aging disabled for err).

Test Plan:
- Reset: after rst, all outputs 0. Single err_valid with code 8'h5A, evt_ready=1 → evt_valid two cycles later with src=1, code=5A, data=0; evt_count=1.
- Priority: all three strobes on one edge (cfg 8'h11, err 8'h22, vga 8'h33 / data 32'hDEADBEEF), evt_ready=1 → consecutive events err, cfg, vga with no bubble; evt_count=3.
- Backpressure: evt_ready=0 for 10 cycles while holding a cfg event → outputs stable; on ready, one accept and one count.
- Overflow: two vga strobes while evt_ready=0 and the slot is full → second strobe dropped, status[5]=1. status_clr → bit clears; status_clr coinciding with a new overflow → bit stays 1.
- Aging: vga pending with err strobed every cycle and evt_ready=1 → vga granted once its age reaches 15, ahead of the pending err.
- Wrap: CNT_W=4, 17 accepted events → evt_count=1.
